// File: rtl/vec_mem_sequencer.sv
// Vector memory sequencer for the MEM stage.
// Serialises VLDW/VLDH/VSTW/VSTH over the single 32-bit data-memory port,
// one lane per cycle, stalling the pipeline while it owns the port.
// When idle, scalar load/store traffic passes straight through.

module vec_mem_sequencer #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic [1:0]          i_vop,
   input  logic [ADDR_W-1:0]   i_base_addr,
   input  logic [32*LANES-1:0] i_vst_data,
   input  logic [ADDR_W-1:0]   i_scalar_addr,
   input  logic [31:0]         i_scalar_wdata,
   input  logic                i_scalar_we,
   input  logic                i_scalar_half,
   input  logic [31:0]         i_mem_rdata,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [31:0]         o_mem_wdata,
   output logic                o_mem_we,
   output logic                o_mem_half,
   output logic                o_stall,
   output logic                o_done,
   output logic                o_vld_we,
   output logic [32*LANES-1:0] o_vld_data
);

   // Lane counter only has to reach LANES-1.
   localparam int              CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // vop encoding: bit 1 selects store, bit 0 selects halfword.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LWAIT,
      S_STORE,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [1:0]          r_vop;
   logic [ADDR_W-1:0]   r_base;
   logic [32*LANES-1:0] r_vst_data;
   logic [CNT_W-1:0]    r_cnt;
   logic [32*LANES-1:0] r_vld_data;

   logic [ADDR_W-1:0]   w_lane_off;
   logic [ADDR_W-1:0]   w_lane_addr;
   logic [31:0]         w_lane_wdata;
   logic [31:0]         w_load_word;
   logic [CNT_W-1:0]    w_cap_idx;

   // Lane address, store word, formatted load word and capture slot.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_lane_off   = r_vop[0] ? (ADDR_W'(r_cnt) << 1) : (ADDR_W'(r_cnt) << 2);
      // Modulo 2^ADDR_W: the sum simply wraps, no alignment check.
      w_lane_addr  = r_base + w_lane_off;
      w_lane_wdata = r_vst_data[32*r_cnt +: 32];
      // Halfword loads are sign-extended from bits [15:0].
      w_load_word  = r_vop[0] ? {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]} : i_mem_rdata;
      // Read data lags the address by one cycle, so LOAD fills lane cnt-1
      // and LWAIT fills the last lane.
      w_cap_idx    = (r_state == S_LWAIT) ? LAST_LANE : (r_cnt - CNT_ONE);
   end

   // Sequencer state, instruction latches, lane counter and load vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_vop      <= '0;
         r_base     <= '0;
         r_vst_data <= '0;
         r_cnt      <= '0;
         // NOTE: the load vector is a small register bank, not a RAM, so it is reset; an abandoned load leaves no partial data.
         r_vld_data <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_vop      <= i_vop;
                  r_base     <= i_base_addr;
                  r_vst_data <= i_vst_data;
                  r_cnt      <= '0;
                  r_state    <= i_vop[1] ? S_STORE : S_LOAD;
               end
            end
            S_LOAD: begin
               if (r_cnt != '0) begin
                  r_vld_data[32*w_cap_idx +: 32] <= w_load_word;
               end
               if (r_cnt == LAST_LANE) begin
                  r_state <= S_LWAIT;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_LWAIT: begin
               r_vld_data[32*w_cap_idx +: 32] <= w_load_word;
               r_state <= S_DONE;
            end
            S_STORE: begin
               if (r_cnt == LAST_LANE) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            // A start still high here belongs to the finished instruction.
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Memory port ownership and pipeline handshake, decoded from state.
   always_comb begin
      o_mem_addr  = i_scalar_addr;
      o_mem_wdata = i_scalar_wdata;
      o_mem_we    = i_scalar_we;
      o_mem_half  = i_scalar_half;
      o_stall     = 1'b0;
      o_done      = 1'b0;
      o_vld_we    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Accept cycle: scalar port still forwarded but writes blocked.
            if (i_start) begin
               o_stall  = 1'b1;
               o_mem_we = 1'b0;
            end
         end
         S_LOAD, S_LWAIT: begin
            o_mem_addr  = w_lane_addr;
            o_mem_wdata = '0;
            o_mem_we    = 1'b0;
            o_mem_half  = r_vop[0];
            o_stall     = 1'b1;
         end
         S_STORE: begin
            o_mem_addr  = w_lane_addr;
            o_mem_wdata = w_lane_wdata;
            o_mem_we    = 1'b1;
            o_mem_half  = r_vop[0];
            o_stall     = 1'b1;
         end
         S_DONE: begin
            o_done   = 1'b1;
            o_vld_we = ~r_vop[1];
         end
         default: begin
            o_stall = 1'b0;
         end
      endcase
   end

   assign o_vld_data = r_vld_data;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: table of vector ops driven
// through a per-cycle scoreboard, plus back-to-back and mid-op reset sequences.

module tb_vec_mem_sequencer;

   localparam int LANES  = 4;
   localparam int ADDR_W = 32;

   localparam logic [31:0]  SC_ADDR   = 32'h5555_0000;
   localparam logic [31:0]  SC_WDATA  = 32'h0BAD_0BAD;
   localparam logic [127:0] VLDW_EXP  = 128'h00000044_00000033_00000022_00000011;
   localparam logic [127:0] VLDH_EXP  = 128'hFFFFFFFF_00000000_00007FFF_FFFF8001;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                i_start = 1'b0;
   logic [1:0]          i_vop = '0;
   logic [ADDR_W-1:0]   i_base_addr = '0;
   logic [32*LANES-1:0] i_vst_data = '0;
   logic [ADDR_W-1:0]   i_scalar_addr = '0;
   logic [31:0]         i_scalar_wdata = '0;
   logic                i_scalar_we = 1'b0;
   logic                i_scalar_half = 1'b0;
   logic [31:0]         i_mem_rdata = '0;
   logic [ADDR_W-1:0]   o_mem_addr;
   logic [31:0]         o_mem_wdata;
   logic                o_mem_we;
   logic                o_mem_half;
   logic                o_stall;
   logic                o_done;
   logic                o_vld_we;
   logic [32*LANES-1:0] o_vld_data;

   vec_mem_sequencer #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_vop         (i_vop),
      .i_base_addr   (i_base_addr),
      .i_vst_data    (i_vst_data),
      .i_scalar_addr (i_scalar_addr),
      .i_scalar_wdata(i_scalar_wdata),
      .i_scalar_we   (i_scalar_we),
      .i_scalar_half (i_scalar_half),
      .i_mem_rdata   (i_mem_rdata),
      .o_mem_addr    (o_mem_addr),
      .o_mem_wdata   (o_mem_wdata),
      .o_mem_we      (o_mem_we),
      .o_mem_half    (o_mem_half),
      .o_stall       (o_stall),
      .o_done        (o_done),
      .o_vld_we      (o_vld_we),
      .o_vld_data    (o_vld_data)
   );

   always #5 clk = ~clk;

   // Data memory model: read data returned the cycle after the address.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] r_addr_q = '0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   always @(negedge clk) r_addr_q = o_mem_addr;
   always @(posedge clk) i_mem_rdata <= mem_rd(r_addr_q);

   // Scoreboard records.
   typedef struct {
      logic        chk_mem;
      logic [31:0] addr;
      logic        we;
      logic        half;
      logic [31:0] wmask;
      logic [31:0] wdata;
      logic        stall;
      logic        done;
      logic        vld_we;
   } cyc_t;

   typedef struct {
      logic [1:0]   vop;
      logic [31:0]  base;
      logic [127:0] vst;
      logic [127:0] exp_vld;
   } vec_t;

   cyc_t         exp_q[$];
   logic [127:0] vld_q[$];
   vec_t         tbl[4];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic push_cyc(input logic chk_mem, input logic [31:0] addr, input logic we,
                           input logic half, input logic [31:0] wmask, input logic [31:0] wdata,
                           input logic stall, input logic done, input logic vld_we);
      cyc_t c;
      c.chk_mem = chk_mem;
      c.addr    = addr;
      c.we      = we;
      c.half    = half;
      c.wmask   = wmask;
      c.wdata   = wdata;
      c.stall   = stall;
      c.done    = done;
      c.vld_we  = vld_we;
      exp_q.push_back(c);
   endtask

   task automatic check_cycle(input string tag);
      cyc_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s scoreboard: got empty queue expected a record", tag);
         return;
      end
      e = exp_q.pop_front();
      check({tag, " stall"},  128'(o_stall),  128'(e.stall));
      check({tag, " done"},   128'(o_done),   128'(e.done));
      check({tag, " vld_we"}, 128'(o_vld_we), 128'(e.vld_we));
      if (e.chk_mem) begin
         check({tag, " addr"},  128'(o_mem_addr), 128'(e.addr));
         check({tag, " we"},    128'(o_mem_we),   128'(e.we));
         check({tag, " half"},  128'(o_mem_half), 128'(e.half));
         check({tag, " wdata"}, 128'(o_mem_wdata & e.wmask), 128'(e.wdata & e.wmask));
      end
   endtask

   task automatic pop_vld(input string tag);
      logic [127:0] want;
      if (vld_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s vld_we: got strobe expected none", tag);
      end else begin
         want = vld_q.pop_front();
         check({tag, " vld_data"}, o_vld_data, want);
      end
   endtask

   // Drives one vector op starting in an IDLE cycle; returns in the IDLE cycle after DONE.
   task automatic run_vec(input vec_t v, input string tag);
      int          step;
      logic        is_load;
      int          ncyc;
      logic [31:0] a;
      step    = v.vop[0] ? 2 : 4;
      is_load = ~v.vop[1];
      ncyc    = is_load ? LANES + 3 : LANES + 2;
      i_start     = 1'b1;
      i_vop       = v.vop;
      i_base_addr = v.base;
      i_vst_data  = v.vst;
      push_cyc(1'b1, SC_ADDR, 1'b0, 1'b0, 32'hFFFF_FFFF, SC_WDATA, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < LANES; i++) begin
         a = v.base + 32'(i * step);
         if (is_load)
            push_cyc(1'b1, a, 1'b0, v.vop[0], 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
         else
            push_cyc(1'b1, a, 1'b1, v.vop[0], v.vop[0] ? 32'h0000_FFFF : 32'hFFFF_FFFF,
                     v.vst[32*i +: 32], 1'b1, 1'b0, 1'b0);
      end
      if (is_load) begin
         push_cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
         vld_q.push_back(v.exp_vld);
      end
      push_cyc(1'b1, SC_ADDR, 1'b1, 1'b0, 32'hFFFF_FFFF, SC_WDATA, 1'b0, 1'b1, is_load);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         check_cycle($sformatf("%s c%0d", tag, c));
         if (o_vld_we) pop_vld(tag);
         if (o_done) check({tag, " held vld_data"}, o_vld_data, v.exp_vld);
         @(posedge clk);
         #1;
         i_start = 1'b0;
      end
   endtask

   initial begin
      int n_done;

      tbl[0] = '{2'b00, 32'h0000_0100, 128'h0, VLDW_EXP};
      tbl[1] = '{2'b01, 32'h0000_0200, 128'h0, VLDH_EXP};
      tbl[2] = '{2'b11, 32'h0000_0300,
                 128'hDDDDDEF0_CCCC9ABC_BBBB5678_AAAA1234, VLDH_EXP};
      tbl[3] = '{2'b10, 32'hFFFF_FFF8,
                 128'h44440004_33330003_22220002_11110001, VLDH_EXP};

      mem[32'h100] = 32'h11;
      mem[32'h104] = 32'h22;
      mem[32'h108] = 32'h33;
      mem[32'h10C] = 32'h44;
      mem[32'h200] = 32'hDEAD_8001;
      mem[32'h202] = 32'h1234_7FFF;
      mem[32'h204] = 32'hABCD_0000;
      mem[32'h206] = 32'h0000_FFFF;

      // Reset state.
      i_scalar_addr  = 32'hCAFE_0000;
      i_scalar_wdata = 32'h0000_1111;
      i_scalar_we    = 1'b1;
      #2;
      check("reset stall",    128'(o_stall),    128'(0));
      check("reset done",     128'(o_done),     128'(0));
      check("reset vld_we",   128'(o_vld_we),   128'(0));
      check("reset vld_data", o_vld_data,       128'(0));
      check("reset mem_addr", 128'(o_mem_addr), 128'(32'hCAFE_0000));
      check("reset mem_we",   128'(o_mem_we),   128'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table of vector ops, scalar port busy with a write throughout.
      i_scalar_addr  = SC_ADDR;
      i_scalar_wdata = SC_WDATA;
      i_scalar_we    = 1'b1;
      i_scalar_half  = 1'b0;
      for (int k = 0; k < 4; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

      // Back-to-back VLDW with start held through DONE into the next IDLE.
      n_done      = 0;
      i_start     = 1'b1;
      i_vop       = 2'b00;
      i_base_addr = 32'h100;
      vld_q.push_back(VLDW_EXP);
      vld_q.push_back(VLDW_EXP);
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         if (o_done) n_done++;
         if ((c >= 0 && c <= 5) || (c >= 7 && c <= 12))
            check($sformatf("b2b c%0d mem_we", c), 128'(o_mem_we), 128'(0));
         if (c == 6 || c == 13)
            check($sformatf("b2b c%0d done", c), 128'(o_done), 128'(1));
         if (c == 7)
            check("b2b reaccept stall", 128'(o_stall), 128'(1));
         if (c == 8)
            check("b2b second lane0 addr", 128'(o_mem_addr), 128'(32'h100));
         if (o_vld_we) pop_vld($sformatf("b2b c%0d", c));
         @(posedge clk);
         #1;
         if (c == 7) i_start = 1'b0;
      end
      check("b2b done count", 128'(n_done), 128'(2));

      // Reset in cycle 2 of a VLDW.
      i_start     = 1'b1;
      i_vop       = 2'b00;
      i_base_addr = 32'h100;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("rst mid stall before", 128'(o_stall), 128'(1));
      rst_n         = 1'b0;
      i_start       = 1'b0;
      i_scalar_addr = 32'h1234_5678;
      #1;
      check("rst mid stall",    128'(o_stall),    128'(0));
      check("rst mid done",     128'(o_done),     128'(0));
      check("rst mid vld_we",   128'(o_vld_we),   128'(0));
      check("rst mid vld_data", o_vld_data,       128'(0));
      check("rst mid mem_addr", 128'(o_mem_addr), 128'(32'h1234_5678));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("post rst c%0d done", c),     128'(o_done),     128'(0));
         check($sformatf("post rst c%0d stall", c),    128'(o_stall),    128'(0));
         check($sformatf("post rst c%0d mem_addr", c), 128'(o_mem_addr), 128'(32'h1234_5678));
         check($sformatf("post rst c%0d mem_we", c),   128'(o_mem_we),   128'(1));
         check($sformatf("post rst c%0d vld_data", c), o_vld_data,       128'(0));
      end

      check("vld queue drained", 128'(vld_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Multi-cycle sequencer that executes vector load/store instructions (VLDW, VLDH, VSTW, VSTH) over the single scalar-width data-memory port. It sits in the MEM stage between the pipeline and data memory. It owns the memory port for the duration of a vector access, issuing one lane per cycle, and stalls the pipeline meanwhile. When no vector access is active it forwards scalar load/store traffic unchanged.

## Interface
- LANES, 4: vector elements per register; ≥2.
- ADDR_W, 32: byte-address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  vector memory instruction present in MEM stage.
- vop  in  2  00 VLDW, 01 VLDH, 10 VSTW, 11 VSTH.
- base_addr  in  ADDR_W  byte address of lane 0.
- vst_data  in  32*LANES  store source vector; lane i = bits [32i+31:32i].
- scalar_addr  in  ADDR_W  scalar port address.
- scalar_wdata  in  32  scalar store data.
- scalar_we  in  1  scalar write enable.
- scalar_half  in  1  scalar access size is halfword.
- mem_rdata  in  32  memory read data, valid the cycle after the address.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable.
- mem_half  out  1  halfword access; data in bits [15:0].
- stall  out  1  freeze the pipeline at MEM and earlier stages.
- done  out  1  one-cycle pulse on completion.
- vld_we  out  1  vector register file write strobe; loads only.
- vld_data  out  32*LANES  assembled load vector.

## Operation
- States: IDLE, LOAD, LWAIT, STORE, DONE.
- IDLE:
  - stall = start.
  - If start=1, latch vop, base_addr and vst_data, clear lane counter, then go to LOAD (vop[1]=0) or STORE (vop[1]=1).
  - start is sampled only in IDLE.
- Lane address: base + lane*stride. Stride is 4 for W and 2 for H. Arithmetic is modulo 2^ADDR_W (wraps); no alignment check.
- LOAD:
  - Issue the lane address with mem_we=0 and mem_half=vop[0].
  - Capture mem_rdata into lane (counter−1) when counter>0.
  - After lane LANES−1, go to LWAIT.
- LWAIT: capture lane LANES−1; go to DONE.
- Load data formats:
  - VLDH lanes are mem_rdata[15:0] sign-extended to 32 bits.
  - VLDW lanes are mem_rdata as returned.
- STORE:
  - mem_we=1, mem_wdata = latched lane (counter), mem_half=vop[0].
  - For VSTH, only bits [15:0] are meaningful.
  - After lane LANES−1, go to DONE.
- DONE:
  - done=1 and stall=0; vld_we=1 if the operation was a load.
  - Always return to IDLE. A start still high in DONE is the same instruction and is not re-accepted. A start in the following IDLE cycle is a new instruction.
- Port ownership:
  - In IDLE (start=0) and DONE, mem_addr/mem_wdata/mem_we/mem_half = scalar_*.
  - In IDLE with start=1, the scalar values are forwarded but mem_we is forced to 0.
  - In LOAD/LWAIT/STORE, the scalar inputs are ignored.
- vld_data holds its value until the next load overwrites it.

## Timing
- Reset (asynchronous, while rst_n=0):
  - State goes to IDLE; counter and latches clear to 0; vld_data=0.
  - done=0, vld_we=0, stall=0 when start=0.
  - mem_* follow the scalar inputs.
  - Reset mid-operation abandons the access: no done pulse, and partial vld_data is discarded.
- Load latency (start seen in cycle 0):
  - Cycles 1..LANES: LOAD, with addresses issued in cycle 1+i for lane i.
  - Cycle LANES+1: LWAIT.
  - Cycle LANES+2: DONE.
  - stall is high for cycles 0..LANES+1 (LANES+2 cycles).
- Store latency:
  - Cycles 1..LANES: STORE, with lane i written in cycle 1+i.
  - Cycle LANES+1: DONE.
  - stall is high for cycles 0..LANES.
- stall, done, vld_we and the mem_* outputs are combinational from state and inputs. vld_data is registered and valid in DONE.
- Back-to-back vector ops: the minimum gap is one IDLE cycle (DONE → IDLE → accept).

## Test plan
- VLDW, base 0x100, LANES=4, mem[0x100..0x10C]=0x11,0x22,0x33,0x44 -> addresses 0x100/0x104/0x108/0x10C in cycles 1–4; DONE in cycle 6 with vld_we=1 and vld_data={0x44,0x33,0x22,0x11}; stall high in cycles 0–5.
- VLDH, base 0x200, halves 0x8001,0x7FFF,0x0000,0xFFFF -> addresses step by 2 with mem_half=1; lanes = 0xFFFF8001, 0x00007FFF, 0x00000000, 0xFFFFFFFF.
- VSTH, base 0x300, vst_data lanes 0xAAAA1234.. -> mem_we=1 in cycles 1–4, addresses 0x300..0x306, mem_wdata[15:0]=0x1234 in lane 0; done in cycle 5; vld_we stays 0.
- VSTW, base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
- start held high through DONE, then a new VLDW in the next IDLE cycle -> exactly two done pulses, separated by one IDLE cycle. Scalar_we=1 during LOAD never reaches mem_we.
- rst_n pulled low in cycle 2 of a VLDW -> outputs reset immediately, vld_data=0, and no done. After release with start=0: stall=0 and the scalar path is forwarded.
